// File: rtl/isp_yuv2rgb_pkg.sv
// Shared constants for the ISP colour-conversion path: BT.601-style YCbCr to
// RGB coefficients in Q8 fixed point, rounding constant and pipeline depths.
package isp_yuv2rgb_pkg;

  localparam int LATENCY   = 5;   // in_* to out_* in pclk cycles
  localparam int ALIGN_LAT = 2;   // chroma alignment stages
  localparam int FRAC      = 8;   // coefficient fraction bits

  localparam int C_RV  = 359;     // R from Vd
  localparam int C_GU  = 88;      // G from Ud (subtracted)
  localparam int C_GV  = 183;     // G from Vd (subtracted)
  localparam int C_BU  = 454;     // B from Ud
  localparam int C_RND = 128;     // half LSB of the Q8 result

  // Line/frame qualifiers travel together through every stage.
  typedef struct packed {
    logic href;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/isp_yuv422_align.sv
// YUV422 chroma alignment: tracks the U/V pixel phase, looks one pixel ahead
// so each pixel leaves with its full (U, V) pair, and covers odd-length lines.
module isp_yuv422_align
  import isp_yuv2rgb_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_c,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_u,
  output logic [BITS-1:0] out_v
);

  localparam logic [BITS-1:0] C_MID = {1'b1, {(BITS-1){1'b0}}};

  logic            phase;     // phase of the pixel currently on in_*
  sync_t           s1_sync;   // lookahead stage
  logic [BITS-1:0] s1_y;
  logic [BITS-1:0] s1_c;
  logic            s1_phase;
  logic [BITS-1:0] held_u;    // U of the current group, for its odd pixel
  logic [BITS-1:0] held_v;    // last V seen on this line, mid-scale if none
  logic [BITS-1:0] u_sel;
  logic [BITS-1:0] v_sel;

  // Pick the chroma pair for the pixel in the lookahead stage. An even pixel
  // borrows V from the pixel now on the input; if the line just ended it
  // falls back to the last V held on the line.
  // NOTE: always_comb assigns every output on every path so no latch forms.
  always_comb begin
    u_sel = s1_c;
    v_sel = held_v;
    if (s1_phase) begin
      u_sel = held_u;
      v_sel = s1_c;
    end else if (in_href) begin
      v_sel = in_c;
    end
  end

  // Phase tracking, lookahead register, held chroma and the aligned output.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, so nothing from before reset
      // can reach the outputs after release.
      phase     <= 1'b0;
      s1_sync   <= '0;
      s1_y      <= '0;
      s1_c      <= '0;
      s1_phase  <= 1'b0;
      held_u    <= '0;
      held_v    <= '0;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_y     <= '0;
      out_u     <= '0;
      out_v     <= '0;
    end else begin
      phase    <= in_href ? ~phase : 1'b0;
      s1_sync  <= '{href: in_href, vsync: in_vsync};
      s1_y     <= in_y;
      s1_c     <= in_c;
      s1_phase <= phase;

      if (s1_sync.href && !s1_phase) held_u <= s1_c;

      if (!s1_sync.href)  held_v <= C_MID;
      else if (s1_phase)  held_v <= s1_c;

      out_href  <= s1_sync.href;
      out_vsync <= s1_sync.vsync;
      out_y     <= s1_y;
      out_u     <= u_sel;
      out_v     <= v_sel;
    end
  end

endmodule

// File: rtl/isp_yuv2rgb.sv
// YUV422 to RGB converter: chroma alignment, Q8 multiply, sum with rounding,
// clamp to the pixel range. One pixel per clock, fixed LATENCY, no stalls.
module isp_yuv2rgb
  import isp_yuv2rgb_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_c,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_r,
  output logic [BITS-1:0] out_g,
  output logic [BITS-1:0] out_b
);

  // Wide enough that Y*256 plus the largest chroma term cannot overflow.
  localparam int SW = BITS + 11;
  localparam logic [BITS:0]          C_MID   = {2'b01, {(BITS-1){1'b0}}};
  localparam logic signed [SW-1:0]   PIX_MAX = SW'((1 << BITS) - 1);

  // Frame geometry is informational only; reject nonsensical values early.
  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_dims
    $error("isp_yuv2rgb: WIDTH and HEIGHT must be positive");
  end

  logic            al_href;
  logic            al_vsync;
  logic [BITS-1:0] al_y;
  logic [BITS-1:0] al_u;
  logic [BITS-1:0] al_v;

  isp_yuv422_align #(.BITS(BITS)) u_align (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_y      (in_y),
    .in_c      (in_c),
    .out_href  (al_href),
    .out_vsync (al_vsync),
    .out_y     (al_y),
    .out_u     (al_u),
    .out_v     (al_v)
  );

  // Chroma offsets; unsigned wrap-around in BITS+1 bits is the two's
  // complement difference.
  logic signed [BITS:0] ud;
  logic signed [BITS:0] vd;
  assign ud = $signed({1'b0, al_u} - C_MID);
  assign vd = $signed({1'b0, al_v} - C_MID);

  sync_t                m_sync;
  logic signed [SW-1:0] m_y, m_rv, m_gu, m_gv, m_bu;
  sync_t                a_sync;
  logic signed [SW-1:0] a_r, a_g, a_b;

  // Drop the Q8 fraction (floor) and saturate into [0, 2^BITS-1].
  function automatic logic [BITS-1:0] clamp_pix(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] q;
    q = acc >>> FRAC;
    if (q[SW-1])          return '0;
    else if (q > PIX_MAX) return '1;
    else                  return q[BITS-1:0];
  endfunction

  // Multiply, sum and clamp stages, with href/vsync riding alongside.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      m_sync    <= '0;
      m_y       <= '0;
      m_rv      <= '0;
      m_gu      <= '0;
      m_gv      <= '0;
      m_bu      <= '0;
      a_sync    <= '0;
      a_r       <= '0;
      a_g       <= '0;
      a_b       <= '0;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      m_sync <= '{href: al_href, vsync: al_vsync};
      m_y    <= $signed(SW'(al_y)) <<< FRAC;
      m_rv   <= SW'(vd) * SW'(C_RV);
      m_gu   <= SW'(ud) * SW'(C_GU);
      m_gv   <= SW'(vd) * SW'(C_GV);
      m_bu   <= SW'(ud) * SW'(C_BU);

      a_sync <= m_sync;
      a_r    <= m_y + m_rv + SW'(C_RND);
      a_g    <= m_y - m_gu - m_gv + SW'(C_RND);
      a_b    <= m_y + m_bu + SW'(C_RND);

      out_href  <= a_sync.href;
      out_vsync <= a_sync.vsync;
      if (a_sync.href) begin
        out_r <= clamp_pix(a_r);
        out_g <= clamp_pix(a_g);
        out_b <= clamp_pix(a_b);
      end else begin
        out_r <= '0;
        out_g <= '0;
        out_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_isp_yuv2rgb.sv
// Self-checking bench for isp_yuv2rgb: directed lines plus random lines, each
// output cycle compared against a pixel-level reference model.
module tb_isp_yuv2rgb;

  localparam int BITS = 8;
  localparam int LAT  = 5;

  logic            pclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_href = 1'b0;
  logic            in_vsync = 1'b0;
  logic [BITS-1:0] in_y = '0;
  logic [BITS-1:0] in_c = '0;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_r;
  logic [BITS-1:0] out_g;
  logic [BITS-1:0] out_b;

  always #5 pclk = ~pclk;

  isp_yuv2rgb #(.BITS(BITS), .WIDTH(1280), .HEIGHT(960)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_y      (in_y),
    .in_c      (in_c),
    .out_href  (out_href),
    .out_vsync (out_vsync),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b)
  );

  typedef struct packed {
    logic            href;
    logic            vsync;
    logic [BITS-1:0] r;
    logic [BITS-1:0] g;
    logic [BITS-1:0] b;
  } obs_t;

  obs_t pipe_q[$];          // expected outputs still travelling through the DUT
  int   vectors     = 0;
  int   miscompares = 0;
  int   line_y[64];
  int   line_c[64];

  // Reference conversion straight from the Q8 equations with integer maths.
  function automatic logic [BITS-1:0] ref_comp(input int y, input int u, input int v,
                                               input int sel);
    int ud, vd, acc;
    ud = u - 128;
    vd = v - 128;
    case (sel)
      0:       acc = y * 256 + 359 * vd + 128;
      1:       acc = y * 256 - 88 * ud - 183 * vd + 128;
      default: acc = y * 256 + 454 * ud + 128;
    endcase
    acc = acc >>> 8;
    if (acc < 0)   acc = 0;
    if (acc > 255) acc = 255;
    return BITS'(acc);
  endfunction

  // One clock: drive inputs, queue what should appear LAT cycles later,
  // then compare the outputs just after the edge.
  task automatic step(input logic h, input logic vs, input logic [BITS-1:0] y,
                      input logic [BITS-1:0] c, input logic rn, input obs_t e,
                      input string tag);
    obs_t want, got;
    @(negedge pclk);
    in_href  = h;
    in_vsync = vs;
    in_y     = y;
    in_c     = c;
    rst_n    = rn;
    pipe_q.push_back(e);
    @(posedge pclk);
    #1;
    if (!rn) begin
      want = '0;
      pipe_q.delete();
      repeat (LAT - 1) pipe_q.push_back('0);
    end else begin
      want = pipe_q.pop_front();
    end
    got = '{href: out_href, vsync: out_vsync, r: out_r, g: out_g, b: out_b};
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got href=%0b vsync=%0b rgb=(%0d,%0d,%0d) want href=%0b vsync=%0b rgb=(%0d,%0d,%0d)",
             tag, got.href, got.vsync, got.r, got.g, got.b,
             want.href, want.vsync, want.r, want.g, want.b);
    end
  endtask

  // Blanking cycles with random data on the bus; the outputs must stay 0.
  task automatic idle(input int k, input logic vs, input string tag);
    obs_t e;
    for (int i = 0; i < k; i++) begin
      e = '{href: 1'b0, vsync: vs, r: '0, g: '0, b: '0};
      step(1'b0, vs, BITS'($urandom), BITS'($urandom), 1'b1, e, tag);
    end
  endtask

  // Drive line_y/line_c[0..n-1] as one active line, pairing chroma by group.
  task automatic run_line(input int n, input logic vs, input string tag);
    obs_t e;
    int u, v;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 1) begin
        u = line_c[i-1];
        v = line_c[i];
      end else begin
        u = line_c[i];
        if (i + 1 < n)  v = line_c[i+1];
        else if (n > 1) v = line_c[n-2];
        else            v = 128;
      end
      e.href  = 1'b1;
      e.vsync = vs;
      e.r     = ref_comp(line_y[i], u, v, 0);
      e.g     = ref_comp(line_y[i], u, v, 1);
      e.b     = ref_comp(line_y[i], u, v, 2);
      step(1'b1, vs, BITS'(line_y[i]), BITS'(line_c[i]), 1'b1, e, tag);
    end
  endtask

  initial begin
    // Reset state.
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, "reset");
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, "reset");
    idle(3, 1'b0, "post_reset_idle");

    // Vertical sync pulse with no active video.
    idle(2, 1'b1, "vsync_pulse");
    idle(2, 1'b0, "vsync_low");

    // Neutral grey line: 128 everywhere, href delayed exactly LAT cycles.
    for (int i = 0; i < 8; i++) begin line_y[i] = 128; line_c[i] = 128; end
    run_line(8, 1'b0, "grey_line");
    idle(6, 1'b0, "grey_tail");

    // All zero: R and B clamp low, G lands mid-range.
    for (int i = 0; i < 4; i++) begin line_y[i] = 0; line_c[i] = 0; end
    run_line(4, 1'b0, "zero_yuv");
    idle(2, 1'b0, "zero_tail");

    // Full luma, neutral U, full V: R and B clamp high.
    for (int i = 0; i < 4; i++) begin
      line_y[i] = 255;
      line_c[i] = (i % 2 == 0) ? 128 : 255;
    end
    run_line(4, 1'b0, "white_red");
    idle(2, 1'b0, "white_tail");

    // Two groups with distinct chroma, back-to-back with a one-cycle gap.
    line_c[0] = 60; line_c[1] = 200; line_c[2] = 180; line_c[3] = 40;
    for (int i = 0; i < 4; i++) line_y[i] = 100;
    run_line(4, 1'b0, "chroma_groups");
    idle(1, 1'b0, "groups_gap");
    run_line(4, 1'b0, "chroma_groups_again");
    idle(2, 1'b0, "groups_tail");

    // Odd-length line reuses its last V; next line restarts at phase 0.
    line_c[0] = 100; line_c[1] = 150; line_c[2] = 90;
    for (int i = 0; i < 3; i++) line_y[i] = 80 + 40 * i;
    run_line(3, 1'b0, "odd_line");
    idle(1, 1'b0, "odd_gap");
    for (int i = 0; i < 4; i++) begin line_y[i] = $urandom_range(0, 255); line_c[i] = $urandom_range(0, 255); end
    run_line(4, 1'b0, "after_odd_line");
    idle(2, 1'b0, "after_odd_tail");

    // Single-pixel line takes mid-scale V.
    line_y[0] = 150; line_c[0] = 30;
    run_line(1, 1'b0, "one_pixel_line");
    idle(3, 1'b0, "one_pixel_tail");

    // Reset for one cycle mid-line: outputs zero at once, nothing left over.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, BITS'($urandom), BITS'($urandom), 1'b1, '0, "pre_reset_line");
    step(1'b1, 1'b0, BITS'($urandom), BITS'($urandom), 1'b0, '0, "mid_line_reset");
    idle(LAT + 2, 1'b0, "post_reset_flush");
    for (int i = 0; i < 5; i++) begin line_y[i] = $urandom_range(0, 255); line_c[i] = $urandom_range(0, 255); end
    run_line(5, 1'b0, "after_reset_line");
    idle(2, 1'b0, "after_reset_tail");

    // Random lines of random length, gap and vsync level.
    for (int l = 0; l < 24; l++) begin
      int   n;
      logic vs;
      n  = $urandom_range(1, 16);
      vs = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
        line_y[i] = $urandom_range(0, 255);
        line_c[i] = $urandom_range(0, 255);
      end
      run_line(n, vs, "random_line");
      idle($urandom_range(1, 3), vs, "random_gap");
    end

    idle(LAT + 1, 1'b0, "final_flush");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
